// File: rtl/downsample_engine.sv
// Hardwired image downsampler: walks FxF source blocks in data RAM and writes
// one decimated or box-averaged pixel per block to a destination buffer.
module downsample_engine #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 16,
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16,
    parameter int LOG2F    = 1,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 16'h1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mode,
    input  logic [DATA_W-1:0] d_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] dout,
    output logic              read,
    output logic              write,
    output logic              finish
);

    localparam int F     = 1 << LOG2F;
    localparam int OW    = IMG_W / F;
    localparam int OH    = IMG_H / F;
    localparam int OXW   = (OW > 1) ? $clog2(OW) : 1;
    localparam int OYW   = (OH > 1) ? $clog2(OH) : 1;
    localparam int ACC_W = DATA_W + 2 * LOG2F;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    state_t             r_state;
    logic               r_mode;
    logic [OXW-1:0]     r_ox;
    logic [OYW-1:0]     r_oy;
    logic [LOG2F-1:0]   r_kx;
    logic [LOG2F-1:0]   r_ky;
    logic [ADDR_W-1:0]  r_dst;
    logic [ACC_W-1:0]   r_acc;

    logic [ADDR_W-1:0]  w_src;
    logic [DATA_W-1:0]  w_avg;
    logic               w_last_x;
    logic               w_last_y;

    assign w_src    = ADDR_W'(SRC_BASE + (int'(r_oy) * F + int'(r_ky)) * IMG_W
                              + int'(r_ox) * F + int'(r_kx));
    assign w_avg    = DATA_W'(r_acc >> (2 * LOG2F));
    assign w_last_x = (r_ox == OXW'(OW - 1));
    assign w_last_y = (r_oy == OYW'(OH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mode   <= 1'b0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_kx     <= '0;
            r_ky     <= '0;
            r_dst    <= '0;
            r_acc    <= '0;
            addr_out <= '0;
            dout     <= '0;
            read     <= 1'b0;
            write    <= 1'b0;
            finish   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    read   <= 1'b0;
                    write  <= 1'b0;
                    finish <= 1'b0;
                    if (enable) begin
                        r_mode  <= mode;
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_kx    <= '0;
                        r_ky    <= '0;
                        r_acc   <= '0;
                        r_dst   <= ADDR_W'(DST_BASE);
                        r_state <= S_RD;
                    end
                end
                // Abort drops strobes on this edge; the access already on the bus completes.
                S_RD, S_CAP, S_WR: begin
                    if (!enable) begin
                        read    <= 1'b0;
                        write   <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_state == S_RD) begin
                        addr_out <= w_src;
                        read     <= 1'b1;
                        write    <= 1'b0;
                        r_state  <= S_CAP;
                    end else if (r_state == S_CAP) begin
                        read  <= 1'b0;
                        r_acc <= r_mode ? r_acc + ACC_W'(d_in) : ACC_W'(d_in);
                        if (!r_mode || (&r_kx && &r_ky)) begin
                            r_state <= S_WR;
                        end else begin
                            r_kx <= r_kx + LOG2F'(1);
                            if (&r_kx) begin
                                r_ky <= r_ky + LOG2F'(1);
                            end
                            r_state <= S_RD;
                        end
                    end else begin
                        addr_out <= r_dst;
                        dout     <= r_mode ? w_avg : r_acc[DATA_W-1:0];
                        write    <= 1'b1;
                        read     <= 1'b0;
                        r_acc    <= '0;
                        r_kx     <= '0;
                        r_ky     <= '0;
                        r_dst    <= r_dst + ADDR_W'(1);
                        if (w_last_x) begin
                            r_ox <= '0;
                            r_oy <= w_last_y ? '0 : r_oy + OYW'(1);
                        end else begin
                            r_ox <= r_ox + OXW'(1);
                        end
                        r_state <= (w_last_x && w_last_y) ? S_DONE : S_RD;
                    end
                end
                S_DONE: begin
                    read   <= 1'b0;
                    write  <= 1'b0;
                    finish <= enable;
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    read    <= 1'b0;
                    write   <= 1'b0;
                    finish  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
